// File: rtl/ascii_frame_streamer.sv
// Captures a sign/hundreds/tens/ones ASCII frame on start and streams it byte by
// byte over valid/ready, with optional zero/plus suppression and a CR/LF tail.
module ascii_frame_streamer #(
    parameter bit SUPPRESS_ZEROS = 1'b1,
    parameter bit SHOW_PLUS      = 1'b1,
    parameter bit TERMINATE_CRLF = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] sign_in,
    input  logic [7:0] ch1_in,
    input  logic [7:0] ch2_in,
    input  logic [7:0] ch3_in,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [47:0] frame_q;
    logic [47:0] frame_d;
    logic [2:0]  len_q;
    logic [2:0]  len_d;
    logic [2:0]  idx_q;
    logic [2:0]  idx_d;
    logic [2:0]  idx_inc;
    logic [7:0]  data_d;
    logic        valid_d;
    logic        handshake;
    logic        last_byte;

    logic [47:0] cap_frame;
    logic [2:0]  cap_len;
    logic        lead_zero;

    // Compacted frame: kept bytes are packed from byte 0 upward, so streaming is a plain index walk.
    always_comb begin
        cap_frame = '0;
        cap_len   = 3'd0;
        lead_zero = SUPPRESS_ZEROS && (ch1_in == 8'h30);

        if (SHOW_PLUS || (sign_in != 8'h2B)) begin
            cap_frame[{cap_len, 3'b000} +: 8] = sign_in;
            cap_len = cap_len + 3'd1;
        end
        if (!lead_zero) begin
            cap_frame[{cap_len, 3'b000} +: 8] = ch1_in;
            cap_len = cap_len + 3'd1;
        end
        if (!(lead_zero && (ch2_in == 8'h30))) begin
            cap_frame[{cap_len, 3'b000} +: 8] = ch2_in;
            cap_len = cap_len + 3'd1;
        end
        cap_frame[{cap_len, 3'b000} +: 8] = ch3_in;
        cap_len = cap_len + 3'd1;
        if (TERMINATE_CRLF) begin
            cap_frame[{cap_len, 3'b000} +: 8] = 8'h0D;
            cap_len = cap_len + 3'd1;
            cap_frame[{cap_len, 3'b000} +: 8] = 8'h0A;
            cap_len = cap_len + 3'd1;
        end
    end

    assign handshake = tx_valid && tx_ready;
    assign idx_inc   = idx_q + 3'd1;
    assign last_byte = (idx_q == (len_q - 3'd1));

    always_comb begin
        state_next = state;
        frame_d    = frame_q;
        len_d      = len_q;
        idx_d      = idx_q;
        data_d     = tx_data;
        valid_d    = tx_valid;

        case (state)
            IDLE: begin
                if (start) begin
                    frame_d    = cap_frame;
                    len_d      = cap_len;
                    idx_d      = 3'd0;
                    data_d     = cap_frame[7:0];
                    valid_d    = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                // The next byte is preloaded on the accepting edge so transfers can run back to back.
                if (handshake) begin
                    if (last_byte) begin
                        valid_d    = 1'b0;
                        state_next = DONE;
                    end else begin
                        idx_d  = idx_inc;
                        data_d = frame_q[{idx_inc, 3'b000} +: 8];
                    end
                end
            end
            DONE: begin
                idx_d      = 3'd0;
                state_next = IDLE;
            end
            default: begin
                valid_d    = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            frame_q  <= '0;
            len_q    <= 3'd0;
            idx_q    <= 3'd0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
        end else begin
            state    <= state_next;
            frame_q  <= frame_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            tx_data  <= data_d;
            tx_valid <= valid_d;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_ascii_frame_streamer.sv
// Four streamers with different option sets share one stimulus; a frame-level
// model checks every cycle and sink logs are compared against hand-written frames.
module tb_ascii_frame_streamer;

    // Instance options, bit i belongs to instance i: 0=(1,1,1) 1=(1,0,1) 2=(1,0,0) 3=(0,0,0)
    localparam logic [3:0] P_SZ = 4'b0111;
    localparam logic [3:0] P_SP = 4'b0001;
    localparam logic [3:0] P_TC = 4'b0011;
    localparam int         LOGN = 128;

    typedef struct packed {
        logic [47:0] b;
        logic [3:0]  n;
    } frame_t;

    logic        clock;
    logic        reset;
    logic        start;
    logic        tx_ready;
    logic [7:0]  sign_in;
    logic [7:0]  ch1_in;
    logic [7:0]  ch2_in;
    logic [7:0]  ch3_in;
    logic [31:0] dat_all;
    logic [3:0]  val;
    logic [3:0]  bsy;
    logic [3:0]  dn;

    int          cmp_count = 0;
    int          fail_count = 0;

    frame_t      cand [4];
    frame_t      frm [4];
    int          rem [4];
    int          sent [4];
    bit          done_due [4];

    logic [7:0]  log_b [4][LOGN];
    int          log_n [4] = '{0, 0, 0, 0};
    int          base [4];
    logic [11:0] pat = 12'b100101101001;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        ascii_frame_streamer #(
            .SUPPRESS_ZEROS(P_SZ[g]),
            .SHOW_PLUS     (P_SP[g]),
            .TERMINATE_CRLF(P_TC[g])
        ) u_dut (
            .clock   (clock),
            .reset   (reset),
            .start   (start),
            .sign_in (sign_in),
            .ch1_in  (ch1_in),
            .ch2_in  (ch2_in),
            .ch3_in  (ch3_in),
            .tx_data (dat_all[g*8 +: 8]),
            .tx_valid(val[g]),
            .tx_ready(tx_ready),
            .busy    (bsy[g]),
            .done    (dn[g])
        );
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // The frame text a streamer must emit for a given input, from the formatting rules alone.
    function automatic frame_t build(input bit sz, input bit sp, input bit tc,
                                     input logic [7:0] s, input logic [7:0] c1,
                                     input logic [7:0] c2, input logic [7:0] c3);
        frame_t f;
        int     n;
        bit     dropping;
        f = '0;
        n = 0;
        dropping = sz;
        if (sp || s != 8'h2B) begin f.b[n*8 +: 8] = s; n++; end
        if (!(dropping && c1 == 8'h30)) begin f.b[n*8 +: 8] = c1; n++; dropping = 1'b0; end
        if (!(dropping && c2 == 8'h30)) begin f.b[n*8 +: 8] = c2; n++; end
        f.b[n*8 +: 8] = c3; n++;
        if (tc) begin
            f.b[n*8 +: 8] = 8'h0D; n++;
            f.b[n*8 +: 8] = 8'h0A; n++;
        end
        f.n = 4'(n);
        return f;
    endfunction

    task automatic chk(input string what, input int inst, input logic [31:0] act, input logic [31:0] exp);
        cmp_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s (dut %0d): got %0h, expected %0h", what, inst, act, exp);
        end
    endtask

    always_comb begin
        for (int i = 0; i < 4; i++)
            cand[i] = build(P_SZ[i], P_SP[i], P_TC[i], sign_in, ch1_in, ch2_in, ch3_in);
    end

    // Frame-level model: bytes left to deliver, position in the frame, and a pending done pulse.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                rem[i]      <= 0;
                sent[i]     <= 0;
                done_due[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                done_due[i] <= (rem[i] == 1) && tx_ready;
                if (rem[i] > 0) begin
                    if (tx_ready) begin
                        rem[i]  <= rem[i] - 1;
                        sent[i] <= sent[i] + 1;
                    end
                end else if (!done_due[i] && start) begin
                    frm[i]  <= cand[i];
                    rem[i]  <= int'(cand[i].n);
                    sent[i] <= 0;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                chk("tx_valid", i, 32'(val[i]), 32'(rem[i] > 0));
                if (rem[i] > 0)
                    chk("tx_data", i, 32'(dat_all[i*8 +: 8]), 32'(frm[i].b[sent[i]*8 +: 8]));
                chk("done", i, 32'(dn[i]), 32'(done_due[i]));
                chk("busy", i, 32'(bsy[i]), 32'((rem[i] > 0) || done_due[i]));
                if (val[i] && tx_ready && log_n[i] < LOGN) begin
                    log_b[i][log_n[i]] = dat_all[i*8 +: 8];
                    log_n[i]++;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] s, input logic [7:0] c1,
                                 input logic [7:0] c2, input logic [7:0] c3);
        @(posedge clock); #1;
        sign_in = s;
        ch1_in  = c1;
        ch2_in  = c2;
        ch3_in  = c3;
        start   = 1'b1;
        @(posedge clock); #1;
        start   = 1'b0;
    endtask

    task automatic waitIdle();
        int c;
        c = 0;
        do begin
            @(posedge clock); #1;
            c++;
        end while (bsy != 4'b0 && c < 400);
        chk("idle within budget", 0, 32'(bsy), 32'(0));
    endtask

    task automatic markBase();
        for (int i = 0; i < 4; i++) base[i] = log_n[i];
    endtask

    // Expected bytes are right-aligned in exp, first byte most significant.
    task automatic checkOutput(input int inst, input int n, input logic [95:0] exp);
        chk("frame length", inst, 32'(log_n[inst] - base[inst]), 32'(n));
        for (int k = 0; k < n; k++) begin
            if (base[inst] + k < LOGN)
                chk($sformatf("frame byte %0d", k), inst,
                    32'(log_b[inst][base[inst] + k]), 32'(exp[(n-1-k)*8 +: 8]));
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        tx_ready = 1'b1;
        sign_in  = 8'h20;
        ch1_in   = 8'h30;
        ch2_in   = 8'h30;
        ch3_in   = 8'h30;
        repeat (3) @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("reset tx_valid", i, 32'(val[i]), 32'(0));
            chk("reset tx_data", i, 32'(dat_all[i*8 +: 8]), 32'(8'h00));
            chk("reset busy", i, 32'(bsy[i]), 32'(0));
            chk("reset done", i, 32'(dn[i]), 32'(0));
        end
        reset = 1'b0;
        @(posedge clock); #1;

        // "-100" at full rate: six consecutive bytes, done one cycle later, then idle
        markBase();
        applyStimulus(8'h2D, 8'h31, 8'h30, 8'h30);
        chk("first byte latency valid", 0, 32'(val[0]), 32'(1));
        chk("first byte latency data", 0, 32'(dat_all[7:0]), 32'(8'h2D));
        repeat (6) @(posedge clock);
        #1;
        chk("done after last byte", 0, 32'(dn[0]), 32'(1));
        chk("valid low in done", 0, 32'(val[0]), 32'(0));
        @(posedge clock); #1;
        chk("done single cycle", 0, 32'(dn[0]), 32'(0));
        chk("busy after done", 0, 32'(bsy[0]), 32'(0));
        waitIdle();
        checkOutput(0, 6, 96'h2D_31_30_30_0D_0A);
        checkOutput(1, 6, 96'h2D_31_30_30_0D_0A);
        checkOutput(2, 4, 96'h2D_31_30_30);
        checkOutput(3, 4, 96'h2D_31_30_30);

        // "+007" then "+050": leading zeros dropped, inner zero kept
        markBase();
        applyStimulus(8'h2B, 8'h30, 8'h30, 8'h37);
        waitIdle();
        checkOutput(0, 4, 96'h2B_37_0D_0A);
        checkOutput(1, 3, 96'h37_0D_0A);
        checkOutput(3, 3, 96'h30_30_37);
        markBase();
        applyStimulus(8'h2B, 8'h30, 8'h35, 8'h30);
        waitIdle();
        checkOutput(1, 4, 96'h35_30_0D_0A);
        checkOutput(3, 3, 96'h30_35_30);

        // "+000": single byte when everything optional is suppressed
        markBase();
        applyStimulus(8'h2B, 8'h30, 8'h30, 8'h30);
        waitIdle();
        checkOutput(2, 1, 96'h30);
        checkOutput(3, 3, 96'h30_30_30);
        checkOutput(0, 4, 96'h2B_30_0D_0A);

        // "-100" with a stalling sink
        markBase();
        applyStimulus(8'h2D, 8'h31, 8'h30, 8'h30);
        for (int k = 0; k < 200; k++) begin
            tx_ready = pat[k % 12];
            if (k == 2) begin
                chk("stall holds valid", 0, 32'(val[0]), 32'(1));
                chk("stall holds data", 0, 32'(dat_all[7:0]), 32'(8'h31));
            end
            if (bsy == 4'b0) break;
            @(posedge clock); #1;
        end
        tx_ready = 1'b1;
        waitIdle();
        checkOutput(0, 6, 96'h2D_31_30_30_0D_0A);
        checkOutput(2, 4, 96'h2D_31_30_30);

        // start during SEND is ignored; start held through DONE captures only once idle
        markBase();
        applyStimulus(8'h2D, 8'h31, 8'h30, 8'h30);
        sign_in = 8'h2B;
        ch1_in  = 8'h39;
        ch2_in  = 8'h39;
        ch3_in  = 8'h39;
        start   = 1'b1;
        @(posedge clock); #1;
        start   = 1'b0;
        for (int c = 0; c < 50 && !dn[0]; c++) begin
            @(posedge clock); #1;
        end
        chk("done reached", 0, 32'(dn[0]), 32'(1));
        start = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        start = 1'b0;
        waitIdle();
        checkOutput(0, 12, 96'h2D_31_30_30_0D_0A_2B_39_39_39_0D_0A);

        // reset after two bytes aborts the frame; the next frame is complete
        applyStimulus(8'h2D, 8'h31, 8'h30, 8'h30);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        chk("abort tx_valid", 0, 32'(val[0]), 32'(0));
        chk("abort tx_data", 0, 32'(dat_all[7:0]), 32'(8'h00));
        repeat (3) begin
            @(posedge clock); #1;
            chk("no done on abort", 0, 32'(dn[0]), 32'(0));
        end
        reset = 1'b0;
        @(posedge clock); #1;
        markBase();
        applyStimulus(8'h2D, 8'h31, 8'h30, 8'h30);
        waitIdle();
        checkOutput(0, 6, 96'h2D_31_30_30_0D_0A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
